multicycle_ctrl_fsm: RTL

//  Main control FSM of the multicycle RV32I core (lw, sw, R-type, I-type ALU, beq, jal).

---
 rtl/multicycle_ctrl_fsm.sv | 211 +++++++++++++++++++++
 1 files changed

// File: rtl/multicycle_ctrl_fsm.sv
// Main control FSM of the multicycle RV32I core: sequences fetch, decode, execute,
// memory and writeback over a shared memory port, and traps on illegal opcodes or memory timeouts.
module multicycle_ctrl_fsm #(
   parameter int MEM_TIMEOUT = 255
) (
   input  logic       clk,
   input  logic       rst,
   input  logic [6:0] op,
   input  logic [2:0] funct3,
   input  logic       funct7b5,
   input  logic       zero,
   input  logic       mem_ready,
   output logic       pc_write,
   output logic       adr_src,
   output logic       mem_read,
   output logic       mem_write,
   output logic       ir_write,
   output logic       reg_write,
   output logic [1:0] result_src,
   output logic [1:0] alu_src_a,
   output logic [1:0] alu_src_b,
   output logic [2:0] alu_control,
   output logic [1:0] imm_src,
   output logic       instr_done,
   output logic       trap,
   output logic [1:0] trap_cause
);

   localparam int CNT_W = (MEM_TIMEOUT > 1) ? $clog2(MEM_TIMEOUT) : 1;
   localparam logic [CNT_W-1:0] TO_LAST = CNT_W'((MEM_TIMEOUT > 0) ? MEM_TIMEOUT - 1 : 0);

   localparam logic [6:0] OP_LW  = 7'b0000011;
   localparam logic [6:0] OP_SW  = 7'b0100011;
   localparam logic [6:0] OP_R   = 7'b0110011;
   localparam logic [6:0] OP_I   = 7'b0010011;
   localparam logic [6:0] OP_JAL = 7'b1101111;
   localparam logic [6:0] OP_BEQ = 7'b1100011;

   localparam logic [2:0] ALU_ADD = 3'b000;
   localparam logic [2:0] ALU_SUB = 3'b001;
   localparam logic [2:0] ALU_AND = 3'b010;
   localparam logic [2:0] ALU_OR  = 3'b011;
   localparam logic [2:0] ALU_SLT = 3'b101;

   typedef enum logic [3:0] {
      S_FETCH, S_DECODE, S_MEMADR, S_MEMREAD, S_MEMWB, S_MEMWRITE,
      S_EXECR, S_EXECI, S_ALUWB, S_JAL, S_BEQ, S_TRAP
   } state_t;

   state_t           r_state;
   state_t           w_next;
   logic [CNT_W-1:0] r_cnt;
   logic [1:0]       r_cause;
   logic [1:0]       w_cause;
   logic             w_wait;
   logic             w_timeout;
   logic [2:0]       w_alu_fn;
   logic             w_pc_write, w_mem_read, w_mem_write, w_ir_write, w_reg_write, w_done;

   assign w_wait    = (r_state == S_FETCH) || (r_state == S_MEMREAD) || (r_state == S_MEMWRITE);
   assign w_timeout = (MEM_TIMEOUT != 0) && w_wait && !mem_ready && (r_cnt == TO_LAST);

   // Wait counter restarts whenever the state changes, so every memory state gets a full budget
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state <= S_FETCH;
         r_cnt   <= '0;
         r_cause <= 2'b00;
      end else begin
         r_state <= w_next;
         if (w_next != r_state)
            r_cnt <= '0;
         else if (w_wait && !mem_ready && r_cnt != TO_LAST)
            r_cnt <= r_cnt + 1'b1;
         if (w_next == S_TRAP && r_state != S_TRAP)
            r_cause <= w_cause;
      end
   end

   always_comb begin
      w_next  = r_state;
      w_cause = 2'b00;
      case (r_state)
         S_FETCH: begin
            if (mem_ready)      w_next = S_DECODE;
            else if (w_timeout) begin w_next = S_TRAP; w_cause = 2'b10; end
         end
         S_DECODE: begin
            case (op)
               OP_LW, OP_SW: w_next = S_MEMADR;
               OP_R:         w_next = S_EXECR;
               OP_I:         w_next = S_EXECI;
               OP_JAL:       w_next = S_JAL;
               OP_BEQ:       w_next = S_BEQ;
               default:      begin w_next = S_TRAP; w_cause = 2'b01; end
            endcase
         end
         S_MEMADR:  w_next = (op == OP_LW) ? S_MEMREAD : S_MEMWRITE;
         S_MEMREAD: begin
            if (mem_ready)      w_next = S_MEMWB;
            else if (w_timeout) begin w_next = S_TRAP; w_cause = 2'b10; end
         end
         S_MEMWRITE: begin
            if (mem_ready)      w_next = S_FETCH;
            else if (w_timeout) begin w_next = S_TRAP; w_cause = 2'b10; end
         end
         S_MEMWB, S_ALUWB, S_BEQ: w_next = S_FETCH;
         S_EXECR, S_EXECI, S_JAL: w_next = S_ALUWB;
         S_TRAP:  w_next = S_TRAP;
         default: w_next = S_FETCH;
      endcase
   end

   // funct7b5 selects sub only for register-register ops; addi with imm[10]=1 is still add
   always_comb begin
      w_alu_fn = ALU_ADD;
      case (funct3)
         3'b000:  w_alu_fn = (r_state == S_EXECR && funct7b5) ? ALU_SUB : ALU_ADD;
         3'b010:  w_alu_fn = ALU_SLT;
         3'b110:  w_alu_fn = ALU_OR;
         3'b111:  w_alu_fn = ALU_AND;
         default: w_alu_fn = ALU_ADD;
      endcase
   end

   always_comb begin
      w_pc_write  = 1'b0;
      adr_src     = 1'b0;
      w_mem_read  = 1'b0;
      w_mem_write = 1'b0;
      w_ir_write  = 1'b0;
      w_reg_write = 1'b0;
      result_src  = 2'b00;
      alu_src_a   = 2'b00;
      alu_src_b   = 2'b00;
      alu_control = ALU_ADD;
      w_done      = 1'b0;
      case (r_state)
         S_FETCH: begin
            w_mem_read = 1'b1;
            alu_src_b  = 2'b10;
            result_src = 2'b10;
            w_ir_write = mem_ready;
            w_pc_write = mem_ready;
         end
         S_DECODE: begin
            alu_src_a = 2'b01;
            alu_src_b = 2'b01;
         end
         S_MEMADR: begin
            alu_src_a = 2'b10;
            alu_src_b = 2'b01;
         end
         S_MEMREAD: begin
            adr_src    = 1'b1;
            w_mem_read = 1'b1;
         end
         S_MEMWB: begin
            result_src  = 2'b01;
            w_reg_write = 1'b1;
            w_done      = 1'b1;
         end
         S_MEMWRITE: begin
            adr_src     = 1'b1;
            w_mem_write = 1'b1;
            w_done      = mem_ready;
         end
         S_EXECR, S_EXECI: begin
            alu_src_a   = 2'b10;
            alu_src_b   = (r_state == S_EXECI) ? 2'b01 : 2'b00;
            alu_control = w_alu_fn;
         end
         S_ALUWB: begin
            w_reg_write = 1'b1;
            w_done      = 1'b1;
         end
         S_JAL: begin
            alu_src_a  = 2'b01;
            alu_src_b  = 2'b10;
            w_pc_write = 1'b1;
         end
         S_BEQ: begin
            alu_src_a   = 2'b10;
            alu_control = ALU_SUB;
            w_pc_write  = zero;
            w_done      = 1'b1;
         end
         default: ;
      endcase
   end

   always_comb begin
      case (op)
         OP_LW, OP_I: imm_src = 2'b01;
         OP_BEQ:      imm_src = 2'b10;
         OP_JAL:      imm_src = 2'b11;
         default:     imm_src = 2'b00;
      endcase
   end

   // Strobes are masked by rst so an asserted reset kills a write in the same cycle
   assign pc_write   = w_pc_write  & ~rst;
   assign mem_read   = w_mem_read  & ~rst;
   assign mem_write  = w_mem_write & ~rst;
   assign ir_write   = w_ir_write  & ~rst;
   assign reg_write  = w_reg_write & ~rst;
   assign instr_done = w_done      & ~rst;
   assign trap       = (r_state == S_TRAP);
   assign trap_cause = r_cause;

endmodule
